// File: rtl/decoder_pipe.sv
// ---------------------------------------------------------------------------
// decoder_pipe
//
// Turns a binary index into a one-hot select vector. A 2-entry output buffer
// sits behind the decoder, with valid/ready handshakes on both sides. It is
// the inverse of the one-hot encoder. Typical uses are register-file write
// enables and ROB/issue-slot selects.
//
// The upstream ready signal comes only from registered state and reset. As a
// result, downstream backpressure never reaches index_ready_o through
// combinational logic.
//
// Indices >= NUM_WIRE decode to an all-zero vector and raise the err flag.
// This case can only happen when NUM_WIRE is not a power of two.
//
// Parameters
//   NUM_WIRE      number of one-hot output wires (>= 2, any value)
//   IDX_W         index width, derived from NUM_WIRE
//
// Ports
//   clk_i         clock, all state updates on the rising edge
//   rst_ni        synchronous active-low reset
//   index_i       binary index to decode
//   index_valid_i index_i is valid
//   index_ready_o block can accept an index this cycle
//   wire_o        one-hot vector of the head entry (zero when empty)
//   wire_err_o    head entry's index was out of range (zero when empty)
//   wire_valid_o  wire_o / wire_err_o are valid
//   wire_ready_i  downstream consumes the head entry this cycle
// ---------------------------------------------------------------------------
module decoder_pipe #(
  parameter  int NUM_WIRE = 16,
  localparam int IDX_W    = $clog2(NUM_WIRE)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [IDX_W-1:0]    index_i,
  input  logic                index_valid_i,
  output logic                index_ready_o,
  output logic [NUM_WIRE-1:0] wire_o,
  output logic                wire_err_o,
  output logic                wire_valid_o,
  input  logic                wire_ready_i
);

  logic [NUM_WIRE-1:0] dec_wire;
  logic                dec_err;

  logic [NUM_WIRE-1:0] mem_wire_q [2];
  logic                mem_err_q  [2];
  logic                head_q;
  logic                tail_q;
  logic [1:0]          count_q;

  logic                push;
  logic                pop;

  // Decode the incoming index. Each wire compares against its own position.
  // Any index that matches no wire is, by construction, out of range. That
  // case leaves the vector at zero and keeps the error flag set.
  always_comb begin
    dec_wire = '0;
    dec_err  = 1'b1;
    for (int i = 0; i < NUM_WIRE; i++) begin
      if (index_i == IDX_W'(i)) begin
        dec_wire[i] = 1'b1;
        dec_err     = 1'b0;
      end
    end
  end

  // Ready is gated by reset so that nothing can be pushed during a reset
  // cycle, even though the buffer state is only cleared at the edge.
  assign index_ready_o = (count_q != 2'd2) && rst_ni;
  assign wire_valid_o  = (count_q != 2'd0);

  assign push = index_valid_i && index_ready_o;
  assign pop  = wire_valid_o && wire_ready_i;

  // Entries that have already been popped stay in storage. The output is
  // therefore gated with valid, which keeps an empty buffer reading as zero.
  assign wire_o     = wire_valid_o ? mem_wire_q[head_q] : '0;
  assign wire_err_o = wire_valid_o ? mem_err_q[head_q]  : 1'b0;

  // Buffer storage and bookkeeping.
  // A push writes the slot under the tail pointer. A pop advances the head.
  // Because the buffer has two slots, each pointer simply toggles.
  // The count absorbs a simultaneous push and pop unchanged. A reset discards
  // everything, including an entry that is being popped in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      for (int e = 0; e < 2; e++) begin
        mem_wire_q[e] <= '0;
        mem_err_q[e]  <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_wire_q[tail_q] <= dec_wire;
        mem_err_q[tail_q]  <= dec_err;
        tail_q             <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_pipe.sv
// ---------------------------------------------------------------------------
// tb_decoder_pipe
//
// Two instances share the same clock, reset and handshake inputs:
//   dut16  NUM_WIRE=16, where every index is in range
//   dut12  NUM_WIRE=12, where indices 12..15 are out of range
//
// Each accepted index pushes the expected response into a per-instance
// queue. The expected response is computed arithmetically from the index.
// A separate monitor samples each instance at the falling edge.
//   - It checks valid/ready against the number of queued entries.
//   - It checks the head against the front of the queue.
//   - It pops the queue whenever the instance hands an entry downstream.
//
// Inputs are driven 1 time unit after the rising edge. Acceptances are
// recorded 2 time units after the falling edge. With this timing, the queues
// always mirror exactly what the buffers should hold when the monitor looks.
// ---------------------------------------------------------------------------
module tb_decoder_pipe;

  typedef struct {
    logic [15:0] wire_v;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  index;
  logic        index_valid;
  logic        wire_ready;

  logic        ready16;
  logic [15:0] wire16;
  logic        err16;
  logic        valid16;

  logic        ready12;
  logic [11:0] wire12;
  logic        err12;
  logic        valid12;

  exp_t        q16[$];
  exp_t        q12[$];

  int          check_count = 0;
  int          error_count = 0;

  decoder_pipe #(.NUM_WIRE(16)) dut16 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .index_i       (index),
    .index_valid_i (index_valid),
    .index_ready_o (ready16),
    .wire_o        (wire16),
    .wire_err_o    (err16),
    .wire_valid_o  (valid16),
    .wire_ready_i  (wire_ready)
  );

  decoder_pipe #(.NUM_WIRE(12)) dut12 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .index_i       (index),
    .index_valid_i (index_valid),
    .index_ready_o (ready12),
    .wire_o        (wire12),
    .wire_err_o    (err12),
    .wire_valid_o  (valid12),
    .wire_ready_i  (wire_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected decode: one bit at the index position when the index is in
  // range, otherwise no bits and the error flag.
  function automatic exp_t model(input int idx, input int num);
    exp_t e;
    e.wire_v = '0;
    e.err    = 1'b0;
    if (idx < num) e.wire_v = 16'd1 << idx;
    else           e.err    = 1'b1;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock cycle of stimulus. Inputs change just after the rising edge.
  // Late in the cycle, the task records whether the index will be taken at
  // the next edge. A reset cycle empties both expectation queues instead.
  task automatic applyStimulus(input logic [3:0] idx, input logic vld,
                               input logic rdy, input logic rst_v,
                               output logic accepted);
    @(posedge clk);
    #1;
    index       = idx;
    index_valid = vld;
    wire_ready  = rdy;
    rst_n       = rst_v;
    #6;
    accepted = 1'b0;
    if (!rst_n) begin
      q16.delete();
      q12.delete();
    end else if (index_valid) begin
      if (ready16) q16.push_back(model(int'(index), 16));
      if (ready12) q12.push_back(model(int'(index), 12));
      accepted = ready16;
    end
  endtask

  task automatic sendIndex(input logic [3:0] idx, input logic rdy);
    logic acc;
    int   n;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      applyStimulus(idx, 1'b1, rdy, 1'b1, acc);
      n++;
    end
    checkOutput("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int cycles, input logic rdy);
    logic acc;
    for (int c = 0; c < cycles; c++) applyStimulus(4'd0, 1'b0, rdy, 1'b1, acc);
  endtask

  // Monitor for the 16-wire instance.
  always @(negedge clk) begin
    checkOutput("valid16", 32'(valid16), 32'(q16.size() != 0));
    checkOutput("ready16", 32'(ready16), 32'(rst_n && q16.size() != 2));
    if (q16.size() != 0) begin
      checkOutput("wire16", 32'(wire16), 32'(q16[0].wire_v));
      checkOutput("err16", 32'(err16), 32'(q16[0].err));
      if (valid16 && wire_ready) void'(q16.pop_front());
    end else begin
      checkOutput("wire16_idle", 32'(wire16), 32'd0);
      checkOutput("err16_idle", 32'(err16), 32'd0);
    end
  end

  // Monitor for the 12-wire instance.
  always @(negedge clk) begin
    checkOutput("valid12", 32'(valid12), 32'(q12.size() != 0));
    checkOutput("ready12", 32'(ready12), 32'(rst_n && q12.size() != 2));
    if (q12.size() != 0) begin
      checkOutput("wire12", 32'(wire12), 32'(q12[0].wire_v));
      checkOutput("err12", 32'(err12), 32'(q12[0].err));
      if (valid12 && wire_ready) void'(q12.pop_front());
    end else begin
      checkOutput("wire12_idle", 32'(wire12), 32'd0);
      checkOutput("err12_idle", 32'(err12), 32'd0);
    end
  end

  initial begin
    logic       acc;
    logic [3:0] cur_idx;
    logic       cur_vld;
    logic       rst_v;

    rst_n       = 1'b0;
    index       = '0;
    index_valid = 1'b0;
    wire_ready  = 1'b0;

    // Reset, then a single index 5 that drains straight away.
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, acc);
    sendIndex(4'd5, 1'b1);
    idle(3, 1'b1);

    // Backpressure: fill with 3 and 9, hold 12 off, then release in order.
    sendIndex(4'd3, 1'b0);
    sendIndex(4'd9, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'd12, 1'b1, 1'b0, 1'b1, acc);
      checkOutput("held_not_accepted", 32'(acc), 32'd0);
    end
    sendIndex(4'd12, 1'b1);
    idle(4, 1'b1);

    // Streaming every index back to back with downstream always ready.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(4'(i), 1'b1, 1'b1, 1'b1, acc);
      checkOutput("stream_accepted", 32'(acc), 32'd1);
    end
    idle(3, 1'b1);

    // Simultaneous push and pop with one entry buffered.
    sendIndex(4'd7, 1'b0);
    applyStimulus(4'd2, 1'b1, 1'b1, 1'b1, acc);
    checkOutput("pushpop_accepted", 32'(acc), 32'd1);
    idle(2, 1'b0);
    idle(3, 1'b1);

    // Out-of-range index for the 12-wire instance, then its top wire.
    sendIndex(4'd13, 1'b0);
    sendIndex(4'd11, 1'b0);
    idle(1, 1'b0);
    idle(3, 1'b1);

    // Reset while full with a pop pending, then confirm nothing survives.
    sendIndex(4'd4, 1'b0);
    sendIndex(4'd6, 1'b0);
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, acc);
    idle(3, 1'b1);

    // Randomised traffic. A refused index is held until it is taken.
    cur_idx = '0;
    cur_vld = 1'b0;
    acc     = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!(cur_vld && !acc)) begin
        cur_vld = ($urandom_range(0, 3) != 0);
        cur_idx = 4'($urandom_range(0, 15));
      end
      rst_v = ($urandom_range(0, 60) != 0);
      applyStimulus(cur_idx, cur_vld, 1'($urandom_range(0, 3) != 0), rst_v, acc);
    end
    idle(5, 1'b1);

    checkOutput("final_drain16", 32'(q16.size()), 32'd0);
    checkOutput("final_drain12", 32'(q12.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
